fetch_unit: RTL



---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding uCISC decode/execute.
// Reads an instruction word and its immediate from consecutive addresses of a
// synchronous block memory (one-cycle read latency), then presents the pair
// over a valid/ready handshake. A redirect from downstream reloads the fetch
// PC and discards any partially fetched pair.
// Optional feature macro: FETCH_COUNT_EN adds the fetch_count output, a
// 16-bit wrapping count of accepted transfers.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        clock_input,
  input  logic        reset,
  output logic [15:0] mem_read_address,
  output logic        mem_read_enable,
  input  logic [15:0] mem_read_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instruction,
  output logic [15:0] out_immediate,
  output logic [15:0] out_pc,
  output logic [15:0] pc_peek,
`ifdef FETCH_COUNT_EN
  output logic [15:0] fetch_count,
`endif
  output logic [1:0]  state_peek
);

  // The capture schedule below assumes data arrives exactly one cycle after the address.
  generate
    if (MEM_LATENCY != 1) begin : g_bad_latency
      $error("fetch_unit: MEM_LATENCY must be 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_INST  = 2'd0,
    S_IMM   = 2'd1,
    S_HOLD  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  // 16-bit wrapping address/counter increment.
  function automatic logic [15:0] wrap_add(input logic [15:0] base, input logic [15:0] inc);
    return base + inc;
  endfunction

  state_t      state_r, state_nxt_s, fsm_state_s;
  logic [15:0] pc_r, pc_nxt_s, fsm_pc_s;
  logic [15:0] mem_addr_s;
  logic        mem_en_s;
  logic        cap_inst_s, cap_imm_s, set_valid_s, clr_valid_s;
  logic        fsm_cap_inst_s, fsm_cap_imm_s, fsm_set_valid_s, fsm_clr_valid_s;
  logic        accept_s;
  logic        out_valid_r;
  logic [15:0] out_instruction_r, out_immediate_r, out_pc_r;

  // Handshake completion; a simultaneous redirect still counts the transfer as accepted.
  assign accept_s = out_valid_r & out_ready;

  // Next-state, memory strobe and capture enables; redirect overrides the sequencing.
  always_comb begin
    fsm_state_s     = state_r;
    fsm_pc_s        = pc_r;
    mem_addr_s      = pc_r;
    mem_en_s        = 1'b0;
    fsm_cap_inst_s  = 1'b0;
    fsm_cap_imm_s   = 1'b0;
    fsm_set_valid_s = 1'b0;
    fsm_clr_valid_s = 1'b0;
    case (state_r)
      S_INST: begin
        mem_en_s    = 1'b1;
        fsm_state_s = S_IMM;
      end
      S_IMM: begin
        mem_addr_s     = wrap_add(pc_r, 16'd1);
        mem_en_s       = 1'b1;
        fsm_cap_inst_s = 1'b1;
        fsm_state_s    = S_HOLD;
      end
      S_HOLD: begin
        fsm_cap_imm_s   = 1'b1;
        fsm_set_valid_s = 1'b1;
        fsm_state_s     = S_VALID;
      end
      S_VALID: begin
        if (out_ready) begin
          fsm_pc_s        = wrap_add(pc_r, 16'd2);
          fsm_clr_valid_s = 1'b1;
          fsm_state_s     = S_INST;
        end else begin
          fsm_state_s = S_VALID;
        end
      end
      default: begin
        fsm_state_s = S_INST;
      end
    endcase

    if (redirect_valid) begin
      state_nxt_s = S_INST;
      pc_nxt_s    = redirect_pc;
      cap_inst_s  = 1'b0;
      cap_imm_s   = 1'b0;
      set_valid_s = 1'b0;
      clr_valid_s = 1'b1;
    end else begin
      state_nxt_s = fsm_state_s;
      pc_nxt_s    = fsm_pc_s;
      cap_inst_s  = fsm_cap_inst_s;
      cap_imm_s   = fsm_cap_imm_s;
      set_valid_s = fsm_set_valid_s;
      clr_valid_s = fsm_clr_valid_s;
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      state_r <= S_INST;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Output pair registers; they only load while out_valid is low, so a stalled pair stays put.
  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      out_valid_r       <= 1'b0;
      out_instruction_r <= 16'h0000;
      out_immediate_r   <= 16'h0000;
      out_pc_r          <= RESET_PC;
    end else begin
      if (cap_inst_s) begin
        out_instruction_r <= mem_read_data;
      end else begin
        out_instruction_r <= out_instruction_r;
      end
      if (cap_imm_s) begin
        out_immediate_r <= mem_read_data;
        out_pc_r        <= pc_r;
      end else begin
        out_immediate_r <= out_immediate_r;
        out_pc_r        <= out_pc_r;
      end
      if (clr_valid_s) begin
        out_valid_r <= 1'b0;
      end else if (set_valid_s) begin
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_r;

  // Accepted-transfer counter; redirects leave it alone.
  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      fetch_count_r <= 16'h0000;
    end else if (accept_s) begin
      fetch_count_r <= wrap_add(fetch_count_r, 16'd1);
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign fetch_count = fetch_count_r;
`endif

  assign mem_read_address = mem_addr_s;
  assign mem_read_enable  = mem_en_s;
  assign out_valid        = out_valid_r;
  assign out_instruction  = out_instruction_r;
  assign out_immediate    = out_immediate_r;
  assign out_pc           = out_pc_r;
  assign pc_peek          = pc_r;
  assign state_peek       = state_r;

endmodule
